// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types for the pipeline hazard unit
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_M  = 2'd1,
    FWD_W  = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } mc_state_t;

  localparam int MC_CNT_W = 4;

endpackage

// File: rtl/mc_tracker.sv
// rtl/mc_tracker.sv - multi-cycle unit occupancy tracker (IDLE/BUSY/WB)
module mc_tracker
  import hazard_pkg::*;
#(
  parameter int AW     = 5,
  parameter int MC_LAT = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          i_start,
  input  logic [AW-1:0] i_waddr,
  output logic          o_busy,
  output logic          o_wb,
  output logic [AW-1:0] o_waddr
);

  localparam logic [MC_CNT_W-1:0] LP_CNT_INIT = MC_CNT_W'(MC_LAT - 2);

  mc_state_t             r_state;
  mc_state_t             w_next;
  logic [MC_CNT_W-1:0]   r_cnt;
  logic [AW-1:0]         r_waddr;
  logic                  w_issue;

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    o_busy  = 1'b0;
    o_wb    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && (i_waddr != '0)) begin
          w_next  = BUSY;
          w_issue = 1'b1;
        end
      end
      BUSY: begin
        o_busy = 1'b1;
        if (r_cnt == '0) w_next = WB;
      end
      WB: begin
        o_busy = 1'b1;
        o_wb   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Counter reaching zero in BUSY marks the last busy cycle before write-back.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt   <= '0;
      r_waddr <= '0;
    end else if (w_issue) begin
      r_cnt   <= LP_CNT_INIT;
      r_waddr <= i_waddr;
    end else if ((r_state == BUSY) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - MC_CNT_W'(1);
    end
  end

  assign o_waddr = r_waddr;

endmodule

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - forwarding, load-use/multi-cycle stall and branch flush control
module pipe_hazard_unit
  import hazard_pkg::*;
#(
  parameter int AW     = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [AW-1:0]    D_ADDR1,
  input  logic [AW-1:0]    D_ADDR2,
  input  logic             D_USE1,
  input  logic             D_USE2,
  input  logic             D_MC_OP,
  input  logic [AW-1:0]    D_WADDR,
  input  logic [AW-1:0]    E_ADDR1,
  input  logic [AW-1:0]    E_ADDR2,
  input  logic [AW-1:0]    E_WADDR,
  input  logic             E_REG_WRITE,
  input  logic             E_MEM_READ,
  input  logic             E_MC_START,
  input  logic             BRANCH_TAKEN,
  input  logic [AW-1:0]    M_WADDR,
  input  logic [AW-1:0]    W_WADDR,
  input  logic             M_REG_WRITE,
  input  logic             W_REG_WRITE,
  output logic [1:0]       FWD_A_SEL,
  output logic [1:0]       FWD_B_SEL,
  output logic             STALL_F,
  output logic             STALL_D,
  output logic             FLUSH_D,
  output logic             FLUSH_E,
  output logic             MC_BUSY,
  output logic             MC_WB,
  output logic [AW-1:0]    MC_WADDR,
  output logic [CNT_W-1:0] STALL_CNT
);

  logic             w_load_use;
  logic             w_mc_hit;
  logic             w_mc_stall;
  logic             w_mc_start;
  logic [CNT_W-1:0] r_stall_cnt;

  always_comb begin
    FWD_A_SEL = FWD_RF;
    FWD_B_SEL = FWD_RF;
    if (M_REG_WRITE && (M_WADDR != '0) && (M_WADDR == E_ADDR1))      FWD_A_SEL = FWD_M;
    else if (W_REG_WRITE && (W_WADDR != '0) && (W_WADDR == E_ADDR1)) FWD_A_SEL = FWD_W;
    if (M_REG_WRITE && (M_WADDR != '0) && (M_WADDR == E_ADDR2))      FWD_B_SEL = FWD_M;
    else if (W_REG_WRITE && (W_WADDR != '0) && (W_WADDR == E_ADDR2)) FWD_B_SEL = FWD_W;
  end

  assign w_load_use = E_MEM_READ && E_REG_WRITE && (E_WADDR != '0) &&
                      ((D_USE1 && (D_ADDR1 == E_WADDR)) || (D_USE2 && (D_ADDR2 == E_WADDR)));

  // A second multi-cycle op waits in decode until the unit is free.
  assign w_mc_hit   = (MC_WADDR != '0) &&
                      ((D_USE1 && (D_ADDR1 == MC_WADDR)) || (D_USE2 && (D_ADDR2 == MC_WADDR)) ||
                       (D_WADDR == MC_WADDR));
  assign w_mc_stall = MC_BUSY && (w_mc_hit || D_MC_OP);

  always_comb begin
    STALL_F = 1'b0;
    STALL_D = 1'b0;
    FLUSH_D = 1'b0;
    FLUSH_E = 1'b0;
    if (BRANCH_TAKEN) begin
      FLUSH_D = 1'b1;
      FLUSH_E = 1'b1;
    end else if (w_load_use || w_mc_stall) begin
      STALL_F = 1'b1;
      STALL_D = 1'b1;
      FLUSH_E = 1'b1;
    end
  end

  assign w_mc_start = E_MC_START && !FLUSH_E;

  mc_tracker #(
    .AW     (AW),
    .MC_LAT (MC_LAT)
  ) u_mc_tracker (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .i_start (w_mc_start),
    .i_waddr (E_WADDR),
    .o_busy  (MC_BUSY),
    .o_wb    (MC_WB),
    .o_waddr (MC_WADDR)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                             r_stall_cnt <= '0;
    else if (STALL_D && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign STALL_CNT = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - self-checking bench for pipe_hazard_unit
module tb_pipe_hazard_unit;

  localparam int AW     = 5;
  localparam int MC_LAT = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST_N;
  logic [AW-1:0] D_ADDR1, D_ADDR2, D_WADDR, E_ADDR1, E_ADDR2, E_WADDR, M_WADDR, W_WADDR;
  logic          D_USE1, D_USE2, D_MC_OP, E_REG_WRITE, E_MEM_READ, E_MC_START, BRANCH_TAKEN;
  logic          M_REG_WRITE, W_REG_WRITE;

  logic [1:0]    FWD_A_SEL, FWD_B_SEL;
  logic          STALL_F, STALL_D, FLUSH_D, FLUSH_E, MC_BUSY, MC_WB;
  logic [AW-1:0] MC_WADDR;
  logic [31:0]   STALL_CNT;

  logic [1:0]    s_fwd_a, s_fwd_b;
  logic          s_stall_f, s_stall_d, s_flush_d, s_flush_e, s_mc_busy, s_mc_wb;
  logic [AW-1:0] s_mc_waddr;
  logic [3:0]    s_stall_cnt;

  pipe_hazard_unit #(.AW(AW), .MC_LAT(MC_LAT), .CNT_W(32)) u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .D_ADDR1(D_ADDR1), .D_ADDR2(D_ADDR2), .D_USE1(D_USE1), .D_USE2(D_USE2),
    .D_MC_OP(D_MC_OP), .D_WADDR(D_WADDR),
    .E_ADDR1(E_ADDR1), .E_ADDR2(E_ADDR2), .E_WADDR(E_WADDR),
    .E_REG_WRITE(E_REG_WRITE), .E_MEM_READ(E_MEM_READ), .E_MC_START(E_MC_START),
    .BRANCH_TAKEN(BRANCH_TAKEN),
    .M_WADDR(M_WADDR), .W_WADDR(W_WADDR), .M_REG_WRITE(M_REG_WRITE), .W_REG_WRITE(W_REG_WRITE),
    .FWD_A_SEL(FWD_A_SEL), .FWD_B_SEL(FWD_B_SEL),
    .STALL_F(STALL_F), .STALL_D(STALL_D), .FLUSH_D(FLUSH_D), .FLUSH_E(FLUSH_E),
    .MC_BUSY(MC_BUSY), .MC_WB(MC_WB), .MC_WADDR(MC_WADDR), .STALL_CNT(STALL_CNT)
  );

  pipe_hazard_unit #(.AW(AW), .MC_LAT(MC_LAT), .CNT_W(4)) u_sat (
    .CLK(CLK), .RST_N(RST_N),
    .D_ADDR1(D_ADDR1), .D_ADDR2(D_ADDR2), .D_USE1(D_USE1), .D_USE2(D_USE2),
    .D_MC_OP(D_MC_OP), .D_WADDR(D_WADDR),
    .E_ADDR1(E_ADDR1), .E_ADDR2(E_ADDR2), .E_WADDR(E_WADDR),
    .E_REG_WRITE(E_REG_WRITE), .E_MEM_READ(E_MEM_READ), .E_MC_START(E_MC_START),
    .BRANCH_TAKEN(BRANCH_TAKEN),
    .M_WADDR(M_WADDR), .W_WADDR(W_WADDR), .M_REG_WRITE(M_REG_WRITE), .W_REG_WRITE(W_REG_WRITE),
    .FWD_A_SEL(s_fwd_a), .FWD_B_SEL(s_fwd_b),
    .STALL_F(s_stall_f), .STALL_D(s_stall_d), .FLUSH_D(s_flush_d), .FLUSH_E(s_flush_e),
    .MC_BUSY(s_mc_busy), .MC_WB(s_mc_wb), .MC_WADDR(s_mc_waddr), .STALL_CNT(s_stall_cnt)
  );

  int tot = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: cycles left until the multi-cycle op retires (0 = idle), last dest, stall total.
  int m_left, m_waddr, m_stalls;
  bit e_fe, e_sd;

  function automatic int fwd_of(input int a);
    if (a != 0 && M_REG_WRITE && int'(M_WADDR) == a) return 1;
    if (a != 0 && W_REG_WRITE && int'(W_WADDR) == a) return 2;
    return 0;
  endfunction

  task automatic check_all();
    bit lu, mcs, busy, st;
    if (!RST_N) begin
      m_left = 0; m_waddr = 0; m_stalls = 0;
    end
    busy = (m_left > 0);
    lu   = E_MEM_READ && E_REG_WRITE && E_WADDR != 0 &&
           ((D_USE1 && D_ADDR1 == E_WADDR) || (D_USE2 && D_ADDR2 == E_WADDR));
    mcs  = busy && (D_MC_OP || (m_waddr != 0 &&
           ((D_USE1 && int'(D_ADDR1) == m_waddr) || (D_USE2 && int'(D_ADDR2) == m_waddr) ||
            int'(D_WADDR) == m_waddr)));
    st   = lu || mcs;
    e_sd = !BRANCH_TAKEN && st;
    e_fe = BRANCH_TAKEN || st;
    chk("fwd_a", FWD_A_SEL, fwd_of(int'(E_ADDR1)));
    chk("fwd_b", FWD_B_SEL, fwd_of(int'(E_ADDR2)));
    chk("stall_f", STALL_F, e_sd);
    chk("stall_d", STALL_D, e_sd);
    chk("flush_d", FLUSH_D, BRANCH_TAKEN);
    chk("flush_e", FLUSH_E, e_fe);
    chk("mc_busy", MC_BUSY, busy);
    chk("mc_wb", MC_WB, m_left == 1);
    chk("mc_waddr", MC_WADDR, m_waddr);
    chk("stall_cnt", STALL_CNT, m_stalls);
    chk("stall_cnt4", s_stall_cnt, (m_stalls > 15) ? 15 : m_stalls);
  endtask

  task automatic tick();
    @(negedge CLK);
    check_all();
    @(posedge CLK);
    if (RST_N) begin
      if (m_left > 0) m_left--;
      else if (E_MC_START && E_WADDR != 0 && !e_fe) begin
        m_left  = MC_LAT;
        m_waddr = int'(E_WADDR);
      end
      if (e_sd) m_stalls++;
    end
    #1;
  endtask

  task automatic clear();
    D_ADDR1 = '0; D_ADDR2 = '0; D_WADDR = '0; E_ADDR1 = '0; E_ADDR2 = '0; E_WADDR = '0;
    M_WADDR = '0; W_WADDR = '0; D_USE1 = 0; D_USE2 = 0; D_MC_OP = 0; E_REG_WRITE = 0;
    E_MEM_READ = 0; E_MC_START = 0; BRANCH_TAKEN = 0; M_REG_WRITE = 0; W_REG_WRITE = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    m_left = 0; m_waddr = 0; m_stalls = 0;
    clear();
    RST_N = 1'b0;
    #2;
    chk("rst_busy", MC_BUSY, 0);
    chk("rst_fwd_a", FWD_A_SEL, 0);
    chk("rst_stall_d", STALL_D, 0);
    repeat (2) tick();
    RST_N = 1'b1;
    tick();

    // Forwarding priority and register-0 exclusion
    E_ADDR1 = 5; M_WADDR = 5; W_WADDR = 5; M_REG_WRITE = 1; W_REG_WRITE = 1;
    #1 chk("fwd_m", FWD_A_SEL, 1);
    tick();
    M_REG_WRITE = 0;
    #1 chk("fwd_w", FWD_A_SEL, 2);
    tick();
    E_ADDR1 = 0; W_WADDR = 0;
    #1 chk("fwd_r0", FWD_A_SEL, 0);
    tick();

    // Load-use: one stall cycle
    clear();
    E_MEM_READ = 1; E_REG_WRITE = 1; E_WADDR = 7; D_ADDR2 = 7; D_USE2 = 1;
    #1 chk("lu_stall", STALL_D, 1);
    chk("lu_cnt0", STALL_CNT, 0);
    tick();
    clear();
    #1 chk("lu_release", STALL_D, 0);
    chk("lu_cnt1", STALL_CNT, 1);
    tick();

    // Multi-cycle op timing
    E_MC_START = 1; E_WADDR = 9;
    tick();
    for (int c = 1; c <= 5; c++) begin
      clear(); D_ADDR1 = 9; D_USE1 = 1;
      #1;
      chk("mc_busy_c", MC_BUSY, c <= 4);
      chk("mc_wb_c", MC_WB, c == 4);
      chk("mc_stall_c", STALL_D, c <= 4);
      tick();
    end

    // Branch during load-use and MC stall
    clear(); E_MC_START = 1; E_WADDR = 9;
    tick();
    for (int c = 1; c <= 5; c++) begin
      clear(); D_ADDR1 = 9; D_USE1 = 1;
      if (c <= 2) begin
        BRANCH_TAKEN = 1; E_MEM_READ = 1; E_REG_WRITE = 1; E_WADDR = 3; D_ADDR2 = 3; D_USE2 = 1;
      end
      #1;
      if (c <= 2) begin
        chk("br_flush_d", FLUSH_D, 1);
        chk("br_flush_e", FLUSH_E, 1);
        chk("br_stall_f", STALL_F, 0);
      end
      chk("br_mc_wb", MC_WB, c == 4);
      tick();
    end

    // Reset in the middle of a multi-cycle op
    clear(); E_MC_START = 1; E_WADDR = 9;
    tick();
    clear(); D_ADDR1 = 9; D_USE1 = 1;
    tick();
    RST_N = 1'b0;
    #1;
    chk("rst_mid_busy", MC_BUSY, 0);
    chk("rst_mid_wb", MC_WB, 0);
    chk("rst_mid_cnt", STALL_CNT, 0);
    chk("rst_mid_cnt4", s_stall_cnt, 0);
    clear();
    repeat (2) tick();
    RST_N = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1 chk("rst_no_wb", MC_WB, 0);
      tick();
    end

    // Saturation of the narrow counter
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
    E_MEM_READ = 1; E_REG_WRITE = 1; E_WADDR = 7; D_ADDR1 = 7; D_USE1 = 1;
    repeat (20) tick();
    clear();
    #1;
    chk("sat_cnt4", s_stall_cnt, 15);
    chk("sat_cnt32", STALL_CNT, 20);
    tick();

    // Randomised traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      RST_N        = ($urandom_range(0, 99) != 0);
      D_ADDR1      = AW'($urandom_range(0, 3));
      D_ADDR2      = AW'($urandom_range(0, 3));
      D_WADDR      = AW'($urandom_range(0, 3));
      E_ADDR1      = AW'($urandom_range(0, 3));
      E_ADDR2      = AW'($urandom_range(0, 3));
      E_WADDR      = AW'($urandom_range(0, 3));
      M_WADDR      = AW'($urandom_range(0, 3));
      W_WADDR      = AW'($urandom_range(0, 3));
      D_USE1       = 1'($urandom);
      D_USE2       = 1'($urandom);
      D_MC_OP      = ($urandom_range(0, 7) == 0);
      E_REG_WRITE  = 1'($urandom);
      E_MEM_READ   = ($urandom_range(0, 3) == 0);
      E_MC_START   = ($urandom_range(0, 3) == 0);
      BRANCH_TAKEN = ($urandom_range(0, 7) == 0);
      M_REG_WRITE  = 1'($urandom);
      W_REG_WRITE  = 1'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
